// File: rtl/rr_arb_pkg.sv
// Shared constants and state encoding for the round-robin decode arbiter.
package rr_arb_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/decoder4to16.sv
// Plain 4-to-16 one-hot decoder, shared by the arbiter grant path.
module decoder4to16 (
  input  logic [3:0]  in,
  output logic [15:0] out
);

  assign out = 16'h0001 << in;

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 16 requesters with hold limit and one dead cycle
// between grants; the granted index drives a shared 4-to-16 decoder.
module rr_decode_arbiter
  import rr_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] winner;
  logic [N_REQ-1:0] dec_out;

  // Descending scan so the smallest circular offset from p is written last.
  function automatic logic [IDX_W-1:0] pick_winner(input logic [N_REQ-1:0] r,
                                                   input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] win;
    win = p;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = p + IDX_W'(i);
      if (r[idx]) win = idx;
    end
    return win;
  endfunction

  assign winner = pick_winner(req, ptr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (enable && (req != '0)) begin
            gnt_idx   <= winner;
            gnt_valid <= 1'b1;
            cnt       <= CNT_W'(1);
            state     <= GRANT;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          // done outranks abandonment, which outranks the hold limit.
          if (done || !req[gnt_idx] || (cnt == HOLD_LIM)) begin
            state     <= GAP;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + IDX_W'(1);
            timeout   <= !done && req[gnt_idx];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  decoder4to16 u_dec (
    .in  (gnt_idx),
    .out (dec_out)
  );

  assign gnt = dec_out & {N_REQ{gnt_valid}};

endmodule
